// File: rtl/porownywanie_pkg.sv
// Shared types and helpers for the signed magnitude comparator.
//   DEFAULT_BITS  : default operand width
//   cmp_t         : partial compare result over a bit range {gt, eq}
//   CMP_PAD       : neutral element for the merge tree (never greater, always equal)
//   cmp_merge     : combines a more-significant range (hi) with a less-significant one (lo)
//   cmp_signed_gt : applies the two's-complement sign rule on top of the magnitude result
package porownywanie_pkg;

    localparam int DEFAULT_BITS = 32;

    typedef struct packed {
        logic gt;
        logic eq;
    } cmp_t;

    localparam cmp_t CMP_PAD = '{gt: 1'b0, eq: 1'b1};

    function automatic cmp_t cmp_merge(input cmp_t hi, input cmp_t lo);
        cmp_t r;
        r.gt = hi.gt | (hi.eq & lo.gt);
        r.eq = hi.eq & lo.eq;
        return r;
    endfunction

    // Differing signs decide on their own (non-negative wins); equal signs
    // fall back to the unsigned compare of the remaining magnitude bits.
    function automatic logic cmp_signed_gt(input logic sign_a, input logic sign_b,
                                           input cmp_t mag);
        logic r;
        if (sign_a != sign_b) r = ~sign_a;
        else                  r = mag.gt;
        return r;
    endfunction

endpackage

// File: rtl/porownywanie_cell.sv
// One-bit leaf of the comparator tree.
//   a, b : one magnitude bit of each operand
//   res  : {gt = a>b, eq = a==b} for this bit
module porownywanie_cell
    import porownywanie_pkg::*;
(
    input  logic a,
    input  logic b,
    output cmp_t res
);

    assign res.gt = a & ~b;
    assign res.eq = ~(a ^ b);

endmodule

// File: rtl/porownywanie_unit.sv
// Registered signed magnitude comparator: o_result = signed(A) > signed(B),
// one clock of latency, new operand pair accepted every cycle.
// There is no handshake: every rising edge with i_rst=0 captures a result
// from whatever is on the operand ports; a reset edge forces the flag to 0.
//   i_clk    : clock, rising edge
//   i_rst    : synchronous active-high reset
//   i_argA   : operand A, signed two's complement
//   i_argB   : operand B, signed two's complement
//   o_result : registered flag, 1 iff A > B (signed)
module porownywanie_unit
    import porownywanie_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [BITS-1:0] i_argA,
    input  logic [BITS-1:0] i_argB,
    output logic            o_result
);

    // Magnitude bits are [BITS-2:0]; the tree is padded up to a power of two.
    localparam int N      = BITS - 1;
    localparam int LEVELS = (N > 1) ? $clog2(N) : 0;
    localparam int P      = 1 << LEVELS;

    // Heap layout: node[0] is the root, children of k are 2k+1 (more
    // significant) and 2k+2. Leaf i sits at P-1+i and holds bit N-1-i so
    // the left-to-right leaf order runs from MSB down to LSB.
    cmp_t node [2*P-1];

    for (genvar i = 0; i < P; i++) begin : g_leaf
        if (i < N) begin : g_cell
            porownywanie_cell u_cell (
                .a   (i_argA[N-1-i]),
                .b   (i_argB[N-1-i]),
                .res (node[P-1+i])
            );
        end else begin : g_pad
            // Pads land below bit 0, where the neutral value cannot change the outcome.
            assign node[P-1+i] = CMP_PAD;
        end
    end

    for (genvar k = 0; k < P-1; k++) begin : g_merge
        assign node[k] = cmp_merge(node[2*k+1], node[2*k+2]);
    end

    logic gt_next;

    always_comb begin
        gt_next = cmp_signed_gt(i_argA[BITS-1], i_argB[BITS-1], node[0]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) o_result <= 1'b0;
        else       o_result <= gt_next;
    end

endmodule

// File: tb/tb_porownywanie_unit.sv
module tb_porownywanie_unit;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a32, b32;
  logic [6:0]  a7, b7;
  logic        res32, res7;

  porownywanie_unit #(.BITS(32)) dut32 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_argA   (a32),
    .i_argB   (b32),
    .o_result (res32)
  );

  porownywanie_unit #(.BITS(7)) dut7 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_argA   (a7),
    .i_argB   (b7),
    .o_result (res7)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // ---------------- behavioural model + scoreboard ----------------
  // Expected flag for each edge: reset wins, otherwise plain signed compare.
  logic [0:0] exp32_q[$];
  logic [0:0] exp7_q[$];

  always @(posedge clk) begin
    exp32_q.push_back(rst ? 1'b0 : 1'($signed(a32) > $signed(b32)));
    exp7_q.push_back(rst ? 1'b0 : 1'($signed(a7) > $signed(b7)));
  end

  always @(negedge clk) begin
    logic [0:0] e;
    if (exp32_q.size() > 0) begin
      e = exp32_q.pop_front();
      n_vec++;
      if (res32 !== e[0]) begin
        n_fail++;
        $display("FAIL model32 t=%0t got=%b want=%b", $time, res32, e[0]);
      end
    end
    if (exp7_q.size() > 0) begin
      e = exp7_q.pop_front();
      n_vec++;
      if (res7 !== e[0]) begin
        n_fail++;
        $display("FAIL model7 t=%0t got=%b want=%b", $time, res7, e[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Apply one operand pair for one edge, then check a hand-computed flag.
  task automatic step(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic r, input logic want);
    @(negedge clk);
    a32 = a;
    b32 = b;
    a7  = a[6:0];
    b7  = b[6:0];
    rst = r;
    @(posedge clk);
    #1;
    n_vec++;
    if (res32 !== want) begin
      n_fail++;
      $display("FAIL %s got=%b want=%b", name, res32, want);
    end
  endtask

  task automatic drive_random();
    @(negedge clk);
    a32 = $urandom;
    b32 = $urandom;
    a7  = 7'($urandom_range(0, 127));
    b7  = 7'($urandom_range(0, 127));
    if ($urandom_range(0, 7) == 0) begin
      b32 = a32;
      b7  = a7;
    end else if ($urandom_range(0, 7) == 0) begin
      b32 = a32 ^ 32'h8000_0000;
      b7  = a7 ^ 7'h40;
    end
    rst = ($urandom_range(0, 31) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    a32 = '0;
    b32 = '0;
    a7  = '0;
    b7  = '0;

    step("reset_holds",    32'd5, 32'd3, 1'b1, 1'b0);
    step("reset_release",  32'd5, 32'd3, 1'b0, 1'b1);
    step("small_gt",       32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1);
    step("small_swap",     32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0);
    step("equal",          32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step("maxpos_minneg",  32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
    step("minneg_maxpos",  32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
    step("neg1_vs_0",      32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
    step("0_vs_neg1",      32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    step("neg_neg",        32'hFFFF_FFFE, 32'hFFFF_FFF0, 1'b0, 1'b1);
    step("stream_1",       32'd1, 32'd0, 1'b0, 1'b1);
    step("stream_2",       32'd0, 32'd1, 1'b0, 1'b0);
    step("stream_3",       32'd2, 32'd2, 1'b0, 1'b0);
    step("burst_1",        32'd1, 32'd0, 1'b0, 1'b1);
    step("burst_rst",      32'd9, 32'd1, 1'b1, 1'b0);
    step("burst_recover",  32'd7, 32'd1, 1'b0, 1'b1);
    step("lsb_only",       32'h1234_5679, 32'h1234_5678, 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++) drive_random();

    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    if (exp32_q.size() != 0 || exp7_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain got=%0d want=0", exp32_q.size() + exp7_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
